// File: rtl/ez8_loader.sv
// Byte-stream boot/debug controller for ez8_cpu: parses LOAD/HALT/RUN packets from a host
// byte source, writes instruction words and sequences the CPU pause/reset inputs.
module ez8_loader #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        cpu_pause,
  output logic        cpu_reset,
  output logic [11:0] instr_writeaddr,
  output logic [15:0] instr_writedata,
  output logic        instr_write_en,
  output logic        busy,
  output logic        error
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle, StAHi, StALo, StCHi, StCLo, StDHi, StDLo, StRst
  } state_e;

  state_e        state_q, state_d;
  logic          ready_q;
  logic          pause_q, pause_d;
  logic          creset_q, creset_d;
  logic [11:0]   addr_q, addr_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [11:0]   waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          accept;
  logic          in_packet;

  assign rx_ready        = ready_q && (state_q != StRst);
  assign accept          = rx_valid && rx_ready;
  assign in_packet       = (state_q != StIdle) && (state_q != StRst);
  assign cpu_pause       = pause_q;
  assign cpu_reset       = creset_q;
  assign instr_writeaddr = waddr_q;
  assign instr_writedata = wdata_q;
  assign instr_write_en  = wen_q;
  assign busy            = (state_q != StIdle);
  assign error           = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      pause_q  <= 1'b1;
      creset_q <= 1'b1;
      addr_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= 1'b1;
      pause_q  <= pause_d;
      creset_q <= creset_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pause_d  = pause_q;
    creset_d = creset_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    err_d    = err_q;
    tmo_d    = '0;
    rcnt_d   = rcnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (rx_data)
            8'h4C: begin
              state_d = StAHi;
              pause_d = 1'b1;
              err_d   = 1'b0;
            end
            8'h48: begin
              pause_d = 1'b1;
              err_d   = 1'b0;
            end
            8'h52: begin
              state_d  = StRst;
              pause_d  = 1'b1;
              creset_d = 1'b1;
              rcnt_d   = '0;
              err_d    = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StAHi: if (accept) begin
        addr_d[11:8] = rx_data[3:0];
        state_d      = StALo;
      end
      StALo: if (accept) begin
        addr_d[7:0] = rx_data;
        state_d     = StCHi;
      end
      StCHi: if (accept) begin
        cnt_d[11:8] = rx_data[3:0];
        state_d     = StCLo;
      end
      StCLo: if (accept) begin
        cnt_d[7:0] = rx_data;
        state_d    = ({cnt_q[11:8], rx_data} == 12'd0) ? StIdle : StDHi;
      end
      StDHi: if (accept) begin
        hi_d    = rx_data;
        state_d = StDLo;
      end
      StDLo: if (accept) begin
        wen_d   = 1'b1;
        wdata_d = {hi_q, rx_data};
        waddr_d = addr_q;
        addr_d  = addr_q + 12'd1;
        cnt_d   = cnt_q - 12'd1;
        state_d = (cnt_q == 12'd1) ? StIdle : StDHi;
      end
      StRst: begin
        // cpu_reset and cpu_pause drop together as the block leaves StRst
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          state_d  = StIdle;
          creset_d = 1'b0;
          pause_d  = 1'b0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Inter-byte watchdog; already-written words are left in place on abort
    if (in_packet && !accept) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = StIdle;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ez8_loader.sv
// Directed bench for ez8_loader: write pulses are checked by a scoreboard monitor, control
// outputs by inline checks.
module tb_ez8_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cpu_pause;
  logic        cpu_reset;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  logic        instr_write_en;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];

  ez8_loader #(.TIMEOUT(1024), .RST_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .cpu_pause       (cpu_pause),
    .cpu_reset       (cpu_reset),
    .instr_writeaddr (instr_writeaddr),
    .instr_writedata (instr_writedata),
    .instr_write_en  (instr_write_en),
    .busy            (busy),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the head of the queue
  always @(negedge clk) begin
    if (!reset && instr_write_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                 instr_writeaddr, instr_writedata);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        if ({instr_writeaddr, instr_writedata} !== e) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   instr_writeaddr, instr_writedata, e[27:16], e[15:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("send_timeout", 32'(b), 32'hFFFF);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] pkt1[9];
    logic [7:0] pkt4[9];
    pkt1 = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    pkt4 = '{8'h4C, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h5A, 8'h5A, 8'hC3, 8'hC3};
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_pause", 32'(cpu_pause), 1);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_outputs", {instr_writeaddr, instr_writedata, instr_write_en, busy, error}, 0);
    reset = 1'b0;
    idle(1);
    chk("ready_after_reset", 32'(rx_ready), 1);

    // 1: two-word load
    exp_q.push_back({12'h010, 16'h1234});
    exp_q.push_back({12'h011, 16'hABCD});
    foreach (pkt1[i]) send(pkt1[i]);
    drop();
    idle(3);
    chk("load1_busy", 32'(busy), 0);
    chk("load1_pause", 32'(cpu_pause), 1);
    chk("load1_cpu_reset", 32'(cpu_reset), 1);
    chk("load1_drained", 32'(exp_q.size()), 0);

    // 2: run
    send(8'h52);
    drop();
    n = 0;
    while (!rx_ready && n < 20) begin
      chk("run_cpu_reset_held", 32'(cpu_reset), 1);
      chk("run_busy", 32'(busy), 1);
      n++;
      @(negedge clk);
    end
    chk("run_cycles", 32'(n), 4);
    chk("run_release", {cpu_reset, cpu_pause, busy}, 0);

    // 3: halt while running
    send(8'h48);
    drop();
    chk("halt_pause", 32'(cpu_pause), 1);
    chk("halt_cpu_reset", 32'(cpu_reset), 0);

    // 4: address wrap
    exp_q.push_back({12'hFFF, 16'h5A5A});
    exp_q.push_back({12'h000, 16'hC3C3});
    foreach (pkt4[i]) send(pkt4[i]);
    drop();
    idle(3);
    chk("wrap_drained", 32'(exp_q.size()), 0);
    chk("wrap_busy", 32'(busy), 0);

    // 5: timeout in data phase
    send(8'h4C); send(8'h00); send(8'h00); send(8'h00); send(8'h05);
    drop();
    idle(1000);
    chk("tmo_early_err", 32'(error), 0);
    chk("tmo_early_busy", 32'(busy), 1);
    idle(30);
    chk("tmo_err", 32'(error), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_pause", 32'(cpu_pause), 1);
    send(8'h48);
    drop();
    chk("halt_clears_err", 32'(error), 0);

    // 6: bad command, then reset mid-load
    send(8'h77);
    drop();
    chk("bad_cmd_err", 32'(error), 1);
    chk("bad_cmd_busy", 32'(busy), 0);
    exp_q.push_back({12'h020, 16'h1122});
    send(8'h4C); send(8'h00); send(8'h20); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rx_ready", 32'(rx_ready), 0);
    chk("mid_rst_ctl", {cpu_pause, cpu_reset}, 2'b11);
    chk("mid_rst_outputs", {instr_writeaddr, instr_writedata, instr_write_en, busy, error}, 0);
    rx_valid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(5);
    chk("mid_rst_idle", {busy, error, instr_write_en}, 0);
    chk("final_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
